// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator.
// - lock_state_e : lock sequencer states (WAIT_LOCK=0, STABLE=1, RUN=2)
// - DIV_RST_DEF  : divide value every channel loads at reset
package clk_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } lock_state_e;

  localparam int DIV_RST_DEF = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One clock-enable channel: programmable down-counter, active/pending divide
// registers and a toggle flop.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   run        : high while the lock sequencer is in RUN
//   sync       : phase-align pulse (honoured only in RUN)
//   wr, wdata  : write strobe and new divide value (0 = disabled)
//   en         : one-cycle enable strobe, period = active divide
//   tgl        : divided square wave, inverts after each strobe
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int DW      = 16,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          sync,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic          en,
  output logic          tgl
);

  logic [DW-1:0] act, pend, cnt;
  logic          tgl_q;

  // Strobe purely from registers; counter sits at 0 outside RUN so every
  // enabled channel fires on the first RUN cycle.
  assign en  = run && (act != '0) && (cnt == '0);
  // Toggle state survives lock loss but is shown as 0 outside RUN.
  assign tgl = run & tgl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act   <= DW'(DIV_RST);
      pend  <= DW'(DIV_RST);
      cnt   <= '0;
      tgl_q <= 1'b0;
    end else begin
      if (wr) pend <= wdata;
      if (!run) begin
        cnt <= '0;
        // a disabled channel adopts a write at once, even outside RUN
        if (act == '0 && wr) act <= wdata;
      end else if (sync) begin
        // a write coinciding with sync is adopted by the same realignment
        act   <= wr ? wdata : pend;
        cnt   <= '0;
        tgl_q <= 1'b0;
      end else if (act == '0) begin
        if (wr) begin
          act <= wdata;
          cnt <= '0;
        end
      end else if (cnt == '0) begin
        // reload point: pending value takes over here so no runt period
        act   <= pend;
        cnt   <= (pend == '0) ? '0 : pend - 1'b1;
        tgl_q <= ~tgl_q;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Clock-enable generator with lock-qualified reset sequencer.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   pll_locked  : PLL lock, asynchronous to clk
//   div_wr      : per-channel write strobes (any number set)
//   div_wdata   : divide value for every selected channel
//   sync        : phase-align pulse for all channels
//   en_out      : per-channel one-cycle enable strobes
//   tgl_out     : per-channel divided square waves
//   sync_rst_n  : downstream reset, released only in RUN
//   locked      : high in RUN
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DW          = 16,
  parameter int DIV_RST     = DIV_RST_DEF,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  input  logic [NCH-1:0] div_wr,
  input  logic [DW-1:0]  div_wdata,
  input  logic           sync,
  output logic [NCH-1:0] en_out,
  output logic [NCH-1:0] tgl_out,
  output logic           sync_rst_n,
  output logic           locked
);

  localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] STB_LAST = SW'(LOCK_CYCLES - 1);

  logic [1:0]    lk_pipe;
  logic          lk_s;
  lock_state_e   state;
  logic [SW-1:0] stb_cnt;
  logic          run_nxt;

  // two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lk_pipe <= '0;
    else        lk_pipe <= {lk_pipe[0], pll_locked};
  end
  assign lk_s = lk_pipe[1];

  // next-cycle RUN, so the registered outputs track the state exactly
  always_comb begin
    run_nxt = 1'b0;
    if (state == STABLE && lk_s && stb_cnt == STB_LAST) run_nxt = 1'b1;
    if (state == RUN && lk_s)                           run_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      stb_cnt    <= '0;
      sync_rst_n <= 1'b0;
      locked     <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: if (lk_s) begin
          state   <= STABLE;
          stb_cnt <= '0;
        end
        STABLE: begin
          if (!lk_s)                    state   <= WAIT_LOCK;
          else if (stb_cnt == STB_LAST) state   <= RUN;
          else                          stb_cnt <= stb_cnt + 1'b1;
        end
        RUN:     if (!lk_s) state <= WAIT_LOCK;
        default: state <= WAIT_LOCK;
      endcase
      sync_rst_n <= run_nxt;
      locked     <= run_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(.DW(DW), .DIV_RST(DIV_RST)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (locked),
      .sync  (sync),
      .wr    (div_wr[i]),
      .wdata (div_wdata),
      .en    (en_out[i]),
      .tgl   (tgl_out[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pll_locked;
  logic [NCH-1:0] div_wr;
  logic [DW-1:0]  div_wdata;
  logic           sync;
  logic [NCH-1:0] en_out, tgl_out;
  logic           sync_rst_n, locked;

  int n_chk  = 0;
  int n_pass = 0;
  int idx    = 0;
  logic [NCH-1:0] en_log  [0:63];
  logic [NCH-1:0] tgl_log [0:63];

  clk_div_gen #(.NCH(NCH), .DW(DW), .DIV_RST(2), .LOCK_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .div_wr     (div_wr),
    .div_wdata  (div_wdata),
    .sync       (sync),
    .en_out     (en_out),
    .tgl_out    (tgl_out),
    .sync_rst_n (sync_rst_n),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // advance one clock, sample 1 time unit after the edge and log outputs
  task automatic tick();
    @(posedge clk);
    #1;
    if (idx < 63) idx++;
    en_log[idx]  = en_out;
    tgl_log[idx] = tgl_out;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; div_wr = '0; div_wdata = '0; sync = 1'b0;
    #25;
    chk("rst_en",     32'(en_out),     32'h0);
    chk("rst_tgl",    32'(tgl_out),    32'h0);
    chk("rst_srst",   32'(sync_rst_n), 32'h0);
    chk("rst_locked", 32'(locked),     32'h0);

    // clean lock release: pll high after edge E0 -> RUN at E19
    tick(); rst_n = 1'b1;
    ticks(3);
    pll_locked = 1'b1;
    ticks(18);
    chk("rel_e18_locked", 32'(locked), 32'h0);
    tick();
    chk("rel_e19_locked", 32'(locked),     32'h1);
    chk("rel_e19_srst",   32'(sync_rst_n), 32'h1);
    chk("rel_e19_en",     32'(en_out),     32'hF);
    tick();
    chk("rel_e20_en",  32'(en_out),  32'h0);
    chk("rel_e20_tgl", 32'(tgl_out), 32'hF);
    tick();
    chk("rel_e21_en", 32'(en_out), 32'hF);

    // lock loss in RUN: drop visible after third edge
    ticks(3);
    pll_locked = 1'b0;
    ticks(2);
    chk("loss_f2_locked", 32'(locked), 32'h1);
    tick();
    chk("loss_f3_locked", 32'(locked),     32'h0);
    chk("loss_f3_srst",   32'(sync_rst_n), 32'h0);
    chk("loss_f3_en",     32'(en_out),     32'h0);
    chk("loss_f3_tgl",    32'(tgl_out),    32'h0);
    tick();
    chk("loss_f4_en", 32'(en_out), 32'h0);

    // one-cycle glitch in STABLE restarts the count: RUN at G28, not G19
    pll_locked = 1'b1;
    ticks(8);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ticks(10);
    chk("glitch_g19_locked", 32'(locked), 32'h0);
    ticks(8);
    chk("glitch_g27_locked", 32'(locked), 32'h0);
    tick();
    chk("glitch_g28_locked", 32'(locked), 32'h1);
    chk("glitch_g28_en",     32'(en_out), 32'hF);
    ticks(2);

    // programming: sync, then ch1 := 5 mid-period
    idx = 0;
    sync = 1'b1; tick(); sync = 1'b0;
    ticks(3);
    div_wr = 4'b0010; div_wdata = 16'd5;
    tick();
    div_wr = '0;
    ticks(11);
    chk("prog_sync_en",   32'(en_log[1]),     32'hF);
    chk("prog_sync_tgl",  32'(tgl_log[1]),    32'h0);
    chk("prog_i2_en",     32'(en_log[2]),     32'h0);
    chk("prog_i2_tgl",    32'(tgl_log[2]),    32'hF);
    chk("prog_ch1_i5",    32'(en_log[5][1]),  32'h1);
    chk("prog_ch1_i7",    32'(en_log[7][1]),  32'h0);
    chk("prog_ch1_i9",    32'(en_log[9][1]),  32'h0);
    chk("prog_ch1_i10",   32'(en_log[10][1]), 32'h1);
    chk("prog_ch1_i15",   32'(en_log[15][1]), 32'h1);
    chk("prog_tgl1_i11",  32'(tgl_log[11][1]), 32'h0);
    chk("prog_tgl1_i15",  32'(tgl_log[15][1]), 32'h0);
    chk("prog_tgl1_i16",  32'(tgl_log[16][1]), 32'h1);
    chk("prog_ch0_i11",   32'(en_log[11][0]), 32'h1);

    // disable ch2 (last strobe at idx17), then re-enable with 3
    div_wr = 4'b0100; div_wdata = 16'd0;
    tick();
    div_wr = '0;
    ticks(7);
    chk("dis_ch2_i17",  32'(en_log[17][2]),  32'h1);
    chk("dis_ch2_i19",  32'(en_log[19][2]),  32'h0);
    chk("dis_ch2_i21",  32'(en_log[21][2]),  32'h0);
    chk("dis_ch2_i23",  32'(en_log[23][2]),  32'h0);
    chk("dis_tgl2_i24", 32'(tgl_log[24][2]), 32'h1);
    div_wr = 4'b0100; div_wdata = 16'd3;
    tick();
    div_wr = '0;
    ticks(6);
    chk("ena_ch2_i25",  32'(en_log[25][2]),  32'h1);
    chk("ena_ch2_i26",  32'(en_log[26][2]),  32'h0);
    chk("ena_ch2_i27",  32'(en_log[27][2]),  32'h0);
    chk("ena_ch2_i28",  32'(en_log[28][2]),  32'h1);
    chk("ena_ch2_i31",  32'(en_log[31][2]),  32'h1);
    chk("ena_tgl2_i26", 32'(tgl_log[26][2]), 32'h0);

    // sync with ch0=3, ch3=7: together at idx7, again at idx28
    idx = 0;
    div_wr = 4'b0001; div_wdata = 16'd3; tick();
    div_wr = 4'b1000; div_wdata = 16'd7; tick();
    div_wr = '0;
    ticks(4);
    sync = 1'b1; tick(); sync = 1'b0;
    ticks(23);
    chk("sync_i7_ch0",  32'(en_log[7][0]),  32'h1);
    chk("sync_i7_ch3",  32'(en_log[7][3]),  32'h1);
    chk("sync_i7_tgl",  32'(tgl_log[7]),    32'h0);
    chk("sync_i10_ch0", 32'(en_log[10][0]), 32'h1);
    chk("sync_i14_ch3", 32'(en_log[14][3]), 32'h1);
    chk("sync_i21_ch0", 32'(en_log[21][0]), 32'h0);
    chk("sync_i21_ch3", 32'(en_log[21][3]), 32'h1);
    chk("sync_i28_ch0", 32'(en_log[28][0]), 32'h1);
    chk("sync_i28_ch3", 32'(en_log[28][3]), 32'h1);

    // async reset mid-RUN: immediate clear, divides back to 2, full relock
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en",     32'(en_out),     32'h0);
    chk("arst_tgl",    32'(tgl_out),    32'h0);
    chk("arst_srst",   32'(sync_rst_n), 32'h0);
    chk("arst_locked", 32'(locked),     32'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(18);
    chk("arst_m18_locked", 32'(locked), 32'h0);
    tick();
    chk("arst_m19_locked", 32'(locked), 32'h1);
    chk("arst_m19_en",     32'(en_out), 32'hF);
    tick();
    chk("arst_m20_en", 32'(en_out), 32'h0);
    tick();
    chk("arst_m21_en", 32'(en_out), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
